axil_timeout: RTL and testbench
===============================

Name: axil_timeout

Overview:
AXI4-lite transaction watchdog. It sits directly downstream of the AXI-lite man-in-the-middle stage, between that stage's master port and the target slave. It forwards one write and one read at a time. If the target does not complete within TIMEOUT cycles, the watchdog terminates the transaction upstream with SLVERR. Late or stalled downstream handshakes are then drained legally, so a hung peripheral cannot lock the interconnect.

Parameters:
ADDR_WIDTH, 32, address bus width in bits
DATA_WIDTH, 32, data bus width in bits
STRB_WIDTH, DATA_WIDTH/8, wstrb width
TIMEOUT, 1024, cycles allowed from forward start to downstream response; must be >= 2
CNT_WIDTH, $clog2(TIMEOUT+1), timeout counter width
ERR_RDATA, 32'hDEADBEEF (sized to DATA_WIDTH), rdata returned on read timeout

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  upstream AW; s_axil_awready out 1
s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  upstream W; s_axil_wready out 1
s_axil_bresp/bvalid  out  2/1  upstream B; s_axil_bready in 1
s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  upstream AR; s_axil_arready out 1
s_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  upstream R; s_axil_rready in 1
m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  downstream AW; m_axil_awready in 1
m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  downstream W; m_axil_wready in 1
m_axil_bresp/bvalid  in  2/1  downstream B; m_axil_bready out 1
m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  downstream AR; m_axil_arready in 1
m_axil_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  downstream R; m_axil_rready out 1

Behaviour:
- Reset: all valid/ready outputs 0; data/resp registers 0; both FSMs IDLE; counters 0. Reset mid-transaction abandons it immediately; no drain on either side.
- Write and read paths are independent FSMs with identical structure: IDLE -> FWD -> RESP -> RET; on timeout the path goes to ERR, then DRAIN.
- Write IDLE:
  - s_awready=!aw_held and s_wready=!w_held; AW and W are registered independently, in any order.
  - When both are held, go to FWD next cycle. m_awvalid and m_wvalid assert the cycle after the second capture.
- Write FWD:
  - Drive m_awvalid/m_wvalid from registers; each drops after its own handshake.
  - When both are done, go to RESP. m_bready=1 in RESP.
- Write RESP: on m_bvalid, capture bresp and go to RET. s_bvalid=1 with the captured bresp, asserted the cycle after the downstream handshake.
- Write RET: on s_bready, go to IDLE.
- Counter: cleared on entry to FWD; increments every cycle in FWD/RESP.
  - Expiry occurs when count==TIMEOUT-1 and the completing downstream handshake is absent that cycle. Next state is then ERR.
  - A downstream response in the expiry cycle wins (normal RET).
- Write ERR:
  - s_bvalid=1, s_bresp=2'b10 (SLVERR).
  - Any still-pending m_awvalid/m_wvalid stays asserted; valids are never retracted.
  - On s_bready: go to IDLE if drain is complete, else DRAIN.
- Write DRAIN:
  - Finish outstanding AW/W handshakes, then m_bready=1 until m_bvalid; the response is discarded. Then go to IDLE.
  - Drain completion may also occur during ERR.
  - Upstream ready stays 0 during ERR/DRAIN.
- Read path: same structure.
  - s_arready=1 in IDLE only.
  - m_arvalid is held until accepted; m_rready=1 in RESP.
  - s_rdata/s_rresp are the captured downstream values.
  - On timeout: s_rdata=ERR_RDATA, s_rresp=2'b10. A late m_rvalid is drained and discarded.
- Minimum latency through the block: 1 cycle in each direction, per channel.
- Exactly one outstanding transaction per direction; simultaneous read and write are fully concurrent.

Optional Feature:
AXIL_TIMEOUT_STATUS_EN.
- Defined: adds outputs wr_timeout (1, pulse on write ERR entry), rd_timeout (1, pulse on read ERR entry), wr_timeout_count (16) and rd_timeout_count (16).
  - The counts are saturating at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- TIMEOUT=16. Write addr 0x10, data 0xA5A5A5A5, slave bvalid 3 cycles after W -> s_bresp=OKAY; m_awaddr=0x10 and m_wdata=0xA5A5A5A5 seen downstream.
- W presented 2 cycles before AW -> single downstream write, correct data, one s_bvalid.
- Write, slave never asserts bvalid -> s_bvalid with SLVERR 16 cycles after FWD entry. Slave then asserts bvalid at cycle 40 -> consumed; no second s_bvalid; next write accepted only after that.
- Read 0x20, slave holds arready=0 for 30 cycles -> SLVERR with rdata 0xDEADBEEF at cycle 16. m_arvalid stays high until cycle 30 handshake; the late rvalid is drained.
- m_bvalid arrives exactly in the expiry cycle -> normal OKAY response, no timeout (wr_timeout=0 with the macro defined).
- Assert rst during RESP with s_bready=0 -> all valids 0 immediately; a new write after reset completes normally.

Source files
------------

// File: rtl/axil_timeout.sv
// axil_timeout: AXI4-lite watchdog that answers SLVERR upstream when the target stalls, then drains the late downstream handshakes.
// Define AXIL_TIMEOUT_STATUS_EN to add timeout pulse and saturating count outputs.
module axil_timeout #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_WIDTH = $clog2(TIMEOUT+1),
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef AXIL_TIMEOUT_STATUS_EN
  output logic                  wr_timeout,
  output logic                  rd_timeout,
  output logic [15:0]           wr_timeout_count,
  output logic [15:0]           rd_timeout_count,
`endif
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);
  typedef enum logic [2:0] {IDLE, FWD, RESP, RET, ERR, DRAIN} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT-1);
  state_t                r_wstate, r_rstate;
  logic                  r_aw_held, r_w_held, r_m_awvalid, r_m_wvalid, r_bdone;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [2:0]            r_awprot, r_arprot;
  logic [DATA_WIDTH-1:0] r_wdata, r_s_rdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [1:0]            r_s_bresp, r_s_rresp;
  logic [CNT_WIDTH-1:0]  r_wcnt, r_rcnt;
  logic                  r_m_arvalid, r_rdone;
  logic w_aw_hs, w_w_hs, w_wgo, w_aw_left, w_w_left, w_b_hs, w_wto;
  logic w_ar_hs, w_ar_left, w_r_hs, w_rto;
  assign s_axil_awready = !rst && r_wstate == IDLE && !r_aw_held;
  assign s_axil_wready  = !rst && r_wstate == IDLE && !r_w_held;
  assign s_axil_bvalid  = r_wstate == RET || r_wstate == ERR;
  assign s_axil_bresp   = r_s_bresp;
  assign m_axil_awaddr  = r_awaddr;
  assign m_axil_awprot  = r_awprot;
  assign m_axil_awvalid = r_m_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_m_wvalid;
  // After a timeout the late B is only accepted once AW and W have both gone out
  assign m_axil_bready  = r_wstate == RESP ||
                          ((r_wstate == ERR || r_wstate == DRAIN) && !r_m_awvalid && !r_m_wvalid && !r_bdone);
  assign s_axil_arready = !rst && r_rstate == IDLE;
  assign s_axil_rvalid  = r_rstate == RET || r_rstate == ERR;
  assign s_axil_rdata   = r_s_rdata;
  assign s_axil_rresp   = r_s_rresp;
  assign m_axil_araddr  = r_araddr;
  assign m_axil_arprot  = r_arprot;
  assign m_axil_arvalid = r_m_arvalid;
  assign m_axil_rready  = r_rstate == RESP ||
                          ((r_rstate == ERR || r_rstate == DRAIN) && !r_m_arvalid && !r_rdone);
  assign w_aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_w_hs    = s_axil_wvalid && s_axil_wready;
  assign w_wgo     = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_aw_left = r_m_awvalid && !m_axil_awready;
  assign w_w_left  = r_m_wvalid && !m_axil_wready;
  assign w_b_hs    = m_axil_bvalid && m_axil_bready;
  assign w_wto     = r_wcnt == LAST && (r_wstate == FWD || (r_wstate == RESP && !w_b_hs));
  assign w_ar_hs   = s_axil_arvalid && s_axil_arready;
  assign w_ar_left = r_m_arvalid && !m_axil_arready;
  assign w_r_hs    = m_axil_rvalid && m_axil_rready;
  assign w_rto     = r_rcnt == LAST && (r_rstate == FWD || (r_rstate == RESP && !w_r_hs));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate    <= IDLE;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
      r_bdone     <= 1'b0;
      r_awaddr    <= '0;
      r_awprot    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_s_bresp   <= '0;
      r_wcnt      <= '0;
    end else begin
      case (r_wstate)
        IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= s_axil_awaddr;
            r_awprot  <= s_axil_awprot;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axil_wdata;
            r_wstrb  <= s_axil_wstrb;
          end
          if (w_wgo) begin
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_m_awvalid <= 1'b1;
            r_m_wvalid  <= 1'b1;
            r_wcnt      <= '0;
            r_wstate    <= FWD;
          end
        end
        FWD, RESP: begin
          r_wcnt      <= r_wcnt + 1'b1;
          r_m_awvalid <= w_aw_left;
          r_m_wvalid  <= w_w_left;
          if (w_wto) begin
            r_s_bresp <= 2'b10;
            r_bdone   <= 1'b0;
            r_wstate  <= ERR;
          end else if (r_wstate == RESP && w_b_hs) begin
            r_s_bresp <= m_axil_bresp;
            r_wstate  <= RET;
          end else if (r_wstate == FWD && !w_aw_left && !w_w_left)
            r_wstate <= RESP;
        end
        RET: if (s_axil_bready) r_wstate <= IDLE;
        ERR, DRAIN: begin
          r_m_awvalid <= w_aw_left;
          r_m_wvalid  <= w_w_left;
          if (w_b_hs) r_bdone <= 1'b1;
          if (r_wstate == ERR && s_axil_bready) r_wstate <= (r_bdone || w_b_hs) ? IDLE : DRAIN;
          else if (r_wstate == DRAIN && w_b_hs) r_wstate <= IDLE;
        end
        default: r_wstate <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate    <= IDLE;
      r_m_arvalid <= 1'b0;
      r_rdone     <= 1'b0;
      r_araddr    <= '0;
      r_arprot    <= '0;
      r_s_rdata   <= '0;
      r_s_rresp   <= '0;
      r_rcnt      <= '0;
    end else begin
      case (r_rstate)
        IDLE: if (w_ar_hs) begin
          r_araddr    <= s_axil_araddr;
          r_arprot    <= s_axil_arprot;
          r_m_arvalid <= 1'b1;
          r_rcnt      <= '0;
          r_rstate    <= FWD;
        end
        FWD, RESP: begin
          r_rcnt      <= r_rcnt + 1'b1;
          r_m_arvalid <= w_ar_left;
          if (w_rto) begin
            r_s_rdata <= ERR_RDATA;
            r_s_rresp <= 2'b10;
            r_rdone   <= 1'b0;
            r_rstate  <= ERR;
          end else if (r_rstate == RESP && w_r_hs) begin
            r_s_rdata <= m_axil_rdata;
            r_s_rresp <= m_axil_rresp;
            r_rstate  <= RET;
          end else if (r_rstate == FWD && !w_ar_left)
            r_rstate <= RESP;
        end
        RET: if (s_axil_rready) r_rstate <= IDLE;
        ERR, DRAIN: begin
          r_m_arvalid <= w_ar_left;
          if (w_r_hs) r_rdone <= 1'b1;
          if (r_rstate == ERR && s_axil_rready) r_rstate <= (r_rdone || w_r_hs) ? IDLE : DRAIN;
          else if (r_rstate == DRAIN && w_r_hs) r_rstate <= IDLE;
        end
        default: r_rstate <= IDLE;
      endcase
    end
  end
`ifdef AXIL_TIMEOUT_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_timeout       <= 1'b0;
      rd_timeout       <= 1'b0;
      wr_timeout_count <= '0;
      rd_timeout_count <= '0;
    end else begin
      wr_timeout <= w_wto;
      rd_timeout <= w_rto;
      if (w_wto && wr_timeout_count != 16'hFFFF) wr_timeout_count <= wr_timeout_count + 1'b1;
      if (w_rto && rd_timeout_count != 16'hFFFF) rd_timeout_count <= rd_timeout_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_axil_timeout.sv
// tb_axil_timeout: scoreboard bench for axil_timeout with TIMEOUT=16 and a scripted downstream slave.
module tb_axil_timeout;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0;
  logic [2:0]  s_axil_awprot = '0, s_axil_arprot = '0;
  logic [3:0]  s_axil_wstrb = 4'hF;
  logic        s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_arvalid = 0;
  logic        s_axil_bready = 1, s_axil_rready = 1;
  logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic        m_axil_awready = 1, m_axil_wready = 1, m_axil_arready = 1;
  logic        m_axil_bvalid = 0, m_axil_rvalid = 0;
  logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;
  logic [31:0] m_axil_rdata = '0;
`ifdef AXIL_TIMEOUT_STATUS_EN
  logic        wr_timeout, rd_timeout;
  logic [15:0] wr_timeout_count, rd_timeout_count;
  int          wto_cnt = 0;
`endif
  int checks = 0, fails = 0;
  int b_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [1:0]  wq[$];
  logic [33:0] rq[$];

  axil_timeout #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
`ifdef AXIL_TIMEOUT_STATUS_EN
    .wr_timeout(wr_timeout), .rd_timeout(rd_timeout),
    .wr_timeout_count(wr_timeout_count), .rd_timeout_count(rd_timeout_count),
`endif
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
    .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready), .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata),
    .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready), .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s_axil_bvalid && s_axil_bready) begin
      b_cnt++;
      if (wq.size() == 0) check("b_unexpected", 64'(s_axil_bvalid), 64'd0);
      else check("bresp", 64'(s_axil_bresp), 64'(wq.pop_front()));
    end
    if (s_axil_rvalid && s_axil_rready) begin
      r_cnt++;
      if (rq.size() == 0) check("r_unexpected", 64'(s_axil_rvalid), 64'd0);
      else check("rresp_rdata", 64'({s_axil_rresp, s_axil_rdata}), 64'(rq.pop_front()));
    end
    if (m_axil_awvalid && m_axil_awready) begin aw_cnt++; last_awaddr = m_axil_awaddr; end
    if (m_axil_wvalid && m_axil_wready) begin w_cnt++; last_wdata = m_axil_wdata; end
    if (m_axil_arvalid && m_axil_arready) begin ar_cnt++; last_araddr = m_axil_araddr; end
`ifdef AXIL_TIMEOUT_STATUS_EN
    if (wr_timeout) wto_cnt++;
`endif
  end

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    s_axil_awaddr = a; s_axil_awvalid = 1;
    do begin @(negedge clk); n++; end while (!s_axil_awready && n < 100);
    check("aw_accept", 64'(s_axil_awready), 64'd1);
    @(posedge clk); #1 s_axil_awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int n = 0;
    s_axil_wdata = d; s_axil_wvalid = 1;
    do begin @(negedge clk); n++; end while (!s_axil_wready && n < 100);
    check("w_accept", 64'(s_axil_wready), 64'd1);
    @(posedge clk); #1 s_axil_wvalid = 0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    s_axil_araddr = a; s_axil_arvalid = 1;
    do begin @(negedge clk); n++; end while (!s_axil_arready && n < 100);
    check("ar_accept", 64'(s_axil_arready), 64'd1);
    @(posedge clk); #1 s_axil_arvalid = 0;
  endtask

  task automatic slave_b(input int dly, input logic [1:0] resp);
    int n = 0;
    repeat (dly) @(posedge clk);
    #1 m_axil_bvalid = 1; m_axil_bresp = resp;
    do begin @(negedge clk); n++; end while (!m_axil_bready && n < 100);
    check("m_b_taken", 64'(m_axil_bready), 64'd1);
    @(posedge clk); #1 m_axil_bvalid = 0; m_axil_bresp = 0;
  endtask

  task automatic slave_r(input int dly, input logic [31:0] d, input logic [1:0] resp);
    int n = 0;
    repeat (dly) @(posedge clk);
    #1 m_axil_rvalid = 1; m_axil_rdata = d; m_axil_rresp = resp;
    do begin @(negedge clk); n++; end while (!m_axil_rready && n < 100);
    check("m_r_taken", 64'(m_axil_rready), 64'd1);
    @(posedge clk); #1 m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check(tag, 64'(wq.size() + rq.size()), 64'd0);
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int k, b0, a0, w0, r0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(s_axil_awready), 64'd0);
    check("rst_arready", 64'(s_axil_arready), 64'd0);
    check("rst_bvalid", 64'(s_axil_bvalid), 64'd0);
    check("rst_m_awvalid", 64'(m_axil_awvalid), 64'd0);
    check("rst_rdata", 64'(s_axil_rdata), 64'd0);
    rst = 0;
    @(negedge clk);
    check("idle_awready", 64'(s_axil_awready), 64'd1);
    @(posedge clk); #1;

    // normal write, B three cycles after W
    wq.push_back(2'b00);
    fork send_aw(32'h10); send_w(32'hA5A5A5A5); join
    slave_b(4, 2'b00);
    wait_empty("wr_ok_done");
    check("wr_ok_awaddr", 64'(last_awaddr), 64'h10);
    check("wr_ok_wdata", 64'(last_wdata), 64'hA5A5A5A5);

    // W ahead of AW
    b0 = b_cnt; a0 = aw_cnt; w0 = w_cnt;
    wq.push_back(2'b00);
    fork
      send_w(32'h5A5A0001);
      begin repeat (2) @(posedge clk); #1 send_aw(32'h14); end
    join
    slave_b(3, 2'b00);
    wait_empty("w_first_done");
    check("w_first_aw_cnt", 64'(aw_cnt - a0), 64'd1);
    check("w_first_w_cnt", 64'(w_cnt - w0), 64'd1);
    check("w_first_wdata", 64'(last_wdata), 64'h5A5A0001);
    check("w_first_awaddr", 64'(last_awaddr), 64'h14);
    check("w_first_b_cnt", 64'(b_cnt - b0), 64'd1);

    // write timeout, late B drained
    b0 = b_cnt;
`ifdef AXIL_TIMEOUT_STATUS_EN
    w0 = wto_cnt;
`endif
    wq.push_back(2'b10);
    fork send_aw(32'h18); send_w(32'h11112222); join
    k = -1;
    do begin @(negedge clk); k++; end while (!s_axil_bvalid && k < 100);
    check("wr_to_latency", 64'(k), 64'd16);
    @(negedge clk);
    check("drain_awready", 64'(s_axil_awready), 64'd0);
    check("drain_bready", 64'(m_axil_bready), 64'd1);
    slave_b(22, 2'b00);
    @(negedge clk);
    check("post_drain_awready", 64'(s_axil_awready), 64'd1);
    check("wr_to_b_cnt", 64'(b_cnt - b0), 64'd1);
`ifdef AXIL_TIMEOUT_STATUS_EN
    check("wr_to_pulse", 64'(wto_cnt - w0), 64'd1);
    check("wr_to_count", 64'(wr_timeout_count), 64'd1);
`endif
    wait_empty("wr_to_done");

    // read timeout with AR stalled 30 cycles
    r0 = r_cnt; a0 = ar_cnt;
    m_axil_arready = 0;
    rq.push_back({2'b10, 32'hDEADBEEF});
    send_ar(32'h20);
    k = -1;
    do begin @(negedge clk); k++; end while (!s_axil_rvalid && k < 100);
    check("rd_to_latency", 64'(k), 64'd16);
    check("rd_to_arvalid", 64'(m_axil_arvalid), 64'd1);
    repeat (14) @(posedge clk);
    #1 check("rd_arvalid_c30", 64'(m_axil_arvalid), 64'd1);
    m_axil_arready = 1;
    slave_r(2, 32'h12345678, 2'b00);
    @(negedge clk);
    check("rd_to_ar_cnt", 64'(ar_cnt - a0), 64'd1);
    check("rd_to_araddr", 64'(last_araddr), 64'h20);
    check("rd_to_r_cnt", 64'(r_cnt - r0), 64'd1);
    check("rd_post_arready", 64'(s_axil_arready), 64'd1);
    wait_empty("rd_to_done");

    // B lands exactly in the expiry cycle
`ifdef AXIL_TIMEOUT_STATUS_EN
    w0 = wto_cnt;
`endif
    wq.push_back(2'b00);
    fork send_aw(32'h1C); send_w(32'h33334444); join
    fork
      slave_b(15, 2'b00);
      begin
        k = -1;
        do begin @(negedge clk); k++; end while (!s_axil_bvalid && k < 100);
        check("edge_latency", 64'(k), 64'd16);
      end
    join
    wait_empty("edge_done");
`ifdef AXIL_TIMEOUT_STATUS_EN
    check("edge_no_pulse", 64'(wto_cnt - w0), 64'd0);
`endif

    // concurrent write and read, EXOKAY read passes through
    wq.push_back(2'b01);
    rq.push_back({2'b01, 32'hCAFEF00D});
    fork
      send_aw(32'h30); send_w(32'h0BADC0DE); send_ar(32'h24);
    join
    fork slave_b(1, 2'b01); slave_r(2, 32'hCAFEF00D, 2'b01); join
    wait_empty("concurrent_done");
    check("conc_araddr", 64'(last_araddr), 64'h24);

    // reset mid-transaction
    s_axil_bready = 0; m_axil_arready = 0;
    fork send_aw(32'h40); send_w(32'h77778888); send_ar(32'h44); join
    repeat (3) @(posedge clk);
    #1 check("pre_rst_bready", 64'(m_axil_bready), 64'd1);
    check("pre_rst_arvalid", 64'(m_axil_arvalid), 64'd1);
    rst = 1;
    #1;
    check("rst_mid_bready", 64'(m_axil_bready), 64'd0);
    check("rst_mid_arvalid", 64'(m_axil_arvalid), 64'd0);
    check("rst_mid_bvalid", 64'(s_axil_bvalid), 64'd0);
    check("rst_mid_rvalid", 64'(s_axil_rvalid), 64'd0);
    @(posedge clk); #1 rst = 0;
    s_axil_bready = 1; m_axil_arready = 1;
    wq.push_back(2'b00);
    fork send_aw(32'h50); send_w(32'h9999AAAA); join
    slave_b(2, 2'b00);
    wait_empty("post_rst_done");
    check("post_rst_awaddr", 64'(last_awaddr), 64'h50);
    check("post_rst_wdata", 64'(last_wdata), 64'h9999AAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
